req_priority_encoder: RTL and testbench
=======================================

Name: req_priority_encoder

Overview:
- Sequential 8-to-3 priority encoder with 74x148-style active-low request inputs, enable, GS and EO flags.
- Complements the team's 2-to-4 active-low decoder: the decoder fans one code out to select lines; this block collapses request lines back into one code.
- Requests are latched as sticky pending bits and served highest-index first through a valid/ack handshake.
- Sits between board-level request sources (buttons, device IRQs) and a consumer FSM that needs a stable code.

Parameters:
- N, 8, number of request lines (power of two, 2..16).
- W, 3, code width; must equal log2(N).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en_l  input  1  active-low enable (G); 1 blocks capture of new requests and blocks new grants.
- req_l  input  N  active-low request lines; bit N-1 has highest priority.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- code  output  W  index of the granted request; held stable while valid=1.
- valid  output  1  code is meaningful.
- gs_l  output  1  active-low group select: 0 when en_l=0 and any pending bit is set.
- eo_l  output  1  active-low enable out: 0 when en_l=0 and no pending bit is set.

Behaviour:
- All outputs are registered. Reset (async, any time, including mid-grant) forces: pending=0, state=IDLE, code=0, valid=0, gs_l=1, eo_l=1. The first capture happens at the first rising edge after reset falls.
- Capture: at every edge with en_l=0, pending |= ~req_l (level-sampled, sticky). With en_l=1, pending is held unchanged.
- Clear: at an edge with state=GRANT and ack=1, pending[code] is cleared.
  - If req_l[code]=0 at that same edge while en_l=0, set wins and the bit stays pending, so a held request is re-granted.
- FSM, 3 states:
  - IDLE: valid=0. If en_l=0 and pending!=0, go to GRANT and load code = highest set pending index.
  - GRANT: valid=1. Code is frozen even if a higher-priority request arrives. If ack=1, go to GAP. Otherwise stay, with no timeout.
  - GAP: valid=0 for exactly one cycle, guaranteeing a visible deassertion between grants. Next state uses IDLE's rule on the updated pending value.
- Latency: req_l low before edge t0 sets pending at t0; valid=1 with code at t1 (one cycle after capture). Back-to-back grants occur every 2 cycles minimum (GRANT+ack, GAP).
- en_l rising while in GRANT: the grant completes normally. After GAP, the FSM stays in IDLE until en_l=0. Pending bits are preserved throughout.
- ack while not in GRANT: ignored.
- gs_l/eo_l: registered from the next-state values of pending and en_l. en_l=1 forces gs_l=1 and eo_l=1.
- code in IDLE/GAP retains its last value; valid is the qualifier.

Decomposition:
- Shared package req_prio_pkg:
  - State encoding constants: ST_IDLE=2'b00, ST_GRANT=2'b01, ST_GAP=2'b10.
  - Default N/W constants.
- One sub-module, prio_enc_comb: purely combinational.
  - Input: N-bit active-high vector.
  - Outputs: W-bit highest-set index and an any flag.
  - Instantiated once on the pending register.

Test Plan:
1. Reset then idle: reset=1 for 20 ns with req_l=8'hFF, en_l=0 -> valid=0, code=0, gs_l=1; after release eo_l=0, valid stays 0.
2. Single request: req_l=8'b1111_1011 for one cycle, ack=0 -> valid=1 with code=3'd2 one cycle after capture, held indefinitely. Pulse ack -> valid=0 for one cycle (GAP), then IDLE, eo_l=0.
3. Priority and freeze: pending bits 2 and 5 set together -> code=5 first. Request 7 arriving mid-GRANT leaves code=5. After ack the sequence is GAP, then code=7, then after ack GAP, then code=2.
4. Held request with simultaneous set/clear: req_l[4] held low, ack each GRANT -> code=4 re-granted every 2 cycles (valid toggles 1,0,1,0).
5. Enable gating: en_l=1 while req_l=8'h00 -> pending unchanged, no grant, gs_l=1, eo_l=1. en_l=0 -> code=7 next cycle.
6. Async reset mid-grant: assert reset between edges during GRANT code=6 -> valid=0, gs_l=1 immediately without waiting for a clock edge; pending cleared, so no re-grant after release unless a request is still low.

Source files
------------

// File: rtl/req_prio_pkg.sv
// Shared types and defaults for the request priority encoder.
// Holds the FSM state encoding and the default line count / code width.
package req_prio_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: highest set bit index plus any flag.
// Ports: vec_i (active-high lines), idx_o (highest set index), any_o.
module prio_enc_comb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Ascending scan: the last hit, i.e. the highest index, wins.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/req_priority_encoder.sv
// Sticky 74x148-style priority encoder with a valid/ack grant handshake.
// Ports: clk, reset (async high), en_l, req_l[N], ack -> code[W],
// valid, gs_l, eo_l. All outputs registered.
module req_priority_encoder
    import req_prio_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_l,
    input  logic [N-1:0] req_l,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_l,
    output logic         eo_l
);

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   set_v, clr_v;
    logic [W-1:0]   code_q, code_d;
    logic           valid_q, valid_d;
    logic           gs_q, gs_d;
    logic           eo_q, eo_d;
    logic [W-1:0]   top_idx;
    logic           any_pend;

    prio_enc_comb #(
        .N(N),
        .W(W)
    ) u_enc (
        .vec_i(pend_q),
        .idx_o(top_idx),
        .any_o(any_pend)
    );

    // Pending update: clear the acked bit, then OR in new
    // requests so a still-held request survives its own ack.
    always_comb begin
        set_v = en_l ? '0 : ~req_l;
        clr_v = '0;
        if (state_q == ST_GRANT && ack) begin
            clr_v[code_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                state_d = (!en_l && any_pend) ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                state_d = ack ? ST_GAP : ST_GRANT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Code loads only on entry to GRANT, so it is frozen while
    // valid and keeps its last value otherwise.
    always_comb begin
        code_d  = code_q;
        if (state_q != ST_GRANT && state_d == ST_GRANT) begin
            code_d = top_idx;
        end
        valid_d = (state_d == ST_GRANT);
        gs_d    = ~(~en_l & (|pend_d));
        eo_d    = ~(~en_l & ~(|pend_d));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            gs_q    <= 1'b1;
            eo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            gs_q    <= gs_d;
            eo_q    <= eo_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign gs_l  = gs_q;
    assign eo_l  = eo_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed table-driven bench for req_priority_encoder.
// Each row: inputs applied, one clock edge, outputs compared.
module tb_req_priority_encoder;

    logic       clk;
    logic       reset;
    logic       en_l;
    logic [7:0] req_l;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       gs_l;
    logic       eo_l;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req_l;
        logic       en_l;
        logic       ack;
        logic       ev;
        logic [2:0] ec;
        logic       egs;
        logic       eeo;
    } vec_t;

    vec_t tbl[$];

    req_priority_encoder dut (
        .clk(clk),
        .reset(reset),
        .en_l(en_l),
        .req_l(req_l),
        .ack(ack),
        .code(code),
        .valid(valid),
        .gs_l(gs_l),
        .eo_l(eo_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v,
                           input logic [2:0] c, input logic g,
                           input logic o);
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        chk({tag, ".code"},  {5'd0, code},  {5'd0, c});
        chk({tag, ".gs_l"},  {7'd0, gs_l},  {7'd0, g});
        chk({tag, ".eo_l"},  {7'd0, eo_l},  {7'd0, o});
    endtask

    task automatic add(input logic [7:0] r, input logic e,
                       input logic a, input logic v,
                       input logic [2:0] c, input logic g,
                       input logic o);
        tbl.push_back('{r, e, a, v, c, g, o});
    endtask

    initial begin
        // single request, held grant, ack, gap, idle
        add(8'hFB, 0, 0, 0, 3'd0, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd2, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd2, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd2, 0, 1);
        add(8'hFF, 0, 1, 0, 3'd2, 1, 0);
        add(8'hFF, 0, 0, 0, 3'd2, 1, 0);
        // priority 5 over 2, freeze against 7, then 7, then 2
        add(8'hDB, 0, 0, 0, 3'd2, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd5, 0, 1);
        add(8'h7F, 0, 0, 1, 3'd5, 0, 1);
        add(8'hFF, 0, 1, 0, 3'd5, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd7, 0, 1);
        add(8'hFF, 0, 1, 0, 3'd7, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd2, 0, 1);
        add(8'hFF, 0, 1, 0, 3'd2, 1, 0);
        add(8'hFF, 0, 0, 0, 3'd2, 1, 0);
        // held request 4: set wins over clear, regrant every 2
        add(8'hEF, 0, 0, 0, 3'd2, 0, 1);
        add(8'hEF, 0, 0, 1, 3'd4, 0, 1);
        add(8'hEF, 0, 1, 0, 3'd4, 0, 1);
        add(8'hEF, 0, 1, 1, 3'd4, 0, 1);
        add(8'hEF, 0, 1, 0, 3'd4, 0, 1);
        add(8'hEF, 0, 1, 1, 3'd4, 0, 1);
        add(8'hFF, 0, 1, 0, 3'd4, 1, 0);
        add(8'hFF, 0, 0, 0, 3'd4, 1, 0);
        // enable gating
        add(8'h00, 1, 0, 0, 3'd4, 1, 1);
        add(8'h00, 1, 0, 0, 3'd4, 1, 1);
        add(8'h00, 0, 0, 0, 3'd4, 0, 1);
        add(8'hFF, 0, 0, 1, 3'd7, 0, 1);
        // en_l rises mid-grant: grant completes, then idle
        add(8'hFF, 1, 0, 1, 3'd7, 1, 1);
        add(8'hFF, 1, 1, 0, 3'd7, 1, 1);
        add(8'hFF, 1, 0, 0, 3'd7, 1, 1);
        add(8'hFF, 1, 0, 0, 3'd7, 1, 1);
        add(8'hFF, 0, 0, 1, 3'd6, 0, 1);

        reset = 1'b1;
        en_l  = 1'b0;
        req_l = 8'hFF;
        ack   = 1'b0;
        #20;
        chk_all("rst", 1'b0, 3'd0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        tick();
        chk_all("idle0", 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk_all("idle1", 1'b0, 3'd0, 1'b1, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            req_l = tbl[i].req_l;
            en_l  = tbl[i].en_l;
            ack   = tbl[i].ack;
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ec,
                    tbl[i].egs, tbl[i].eeo);
        end

        // async reset between edges while granting code 6
        ack   = 1'b0;
        req_l = 8'hFF;
        #3;
        reset = 1'b1;
        #1;
        chk_all("arst", 1'b0, 3'd0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        tick();
        chk_all("arst_rel0", 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk_all("arst_rel1", 1'b0, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
